sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

Queue controller that drives a one-read/one-write SRAM wrapper from the initiator side. It turns a valid/ready enqueue stream into SRAM writes and SRAM reads into a valid/ready dequeue stream. A 2-entry output buffer hides the SRAM's 1-cycle read latency. It sits between DANA producer/consumer units and an external `sram_r1_w1_rw0` instance, whose ports it drives directly.

## Interface
- `WIDTH`, 8, data word width
- `DEPTH`, 64, SRAM entries; must equal 2^LG_DEPTH
- `LG_DEPTH`, 6, SRAM address width
- `clk` input 1 single clock, all logic on rising edge
- `reset_n` input 1 synchronous, active-low reset
- `io_enq_valid` input 1 producer has a word
- `io_enq_ready` output 1 controller accepts a word this cycle
- `io_enq_bits` input WIDTH enqueued word
- `io_deq_valid` output 1 head word available
- `io_deq_ready` input 1 consumer takes head word
- `io_deq_bits` output WIDTH head word (registered)
- `io_count` output LG_DEPTH+2 total occupancy: SRAM, in-flight read and output buffer
- `io_sram_dinW` output WIDTH SRAM write data (= `io_enq_bits`)
- `io_sram_addrW` output LG_DEPTH SRAM write address (= wr_ptr)
- `io_sram_weW` output 1 SRAM write enable
- `io_sram_addrR` output LG_DEPTH SRAM read address (= rd_ptr)
- `io_sram_doutR` input WIDTH SRAM read data, valid 1 cycle after the address

## Operation
- State registers:
  - wr_ptr, rd_ptr: LG_DEPTH bits each; wrap naturally at DEPTH.
  - mem_count: 0..DEPTH, committed SRAM entries.
  - rd_pend: read issued last cycle.
  - obuf: 2-entry FIFO of valid+data, head at slot 0.
- Enqueue:
  - `io_enq_ready` = (mem_count < DEPTH). It is registered-derived and never depends on `io_deq_ready`.
  - enq_fire = valid & ready. It drives `io_sram_weW`=1 and increments wr_ptr.
- Read issue:
  - rd_fire = (mem_count > 0) & (obuf_occ + rd_pend - deq_fire < 2).
  - On rd_fire: rd_ptr++, and rd_pend is set next cycle.
  - `io_sram_addrR` is always rd_ptr.
- Capture: when rd_pend=1, `io_sram_doutR` is written into the first free obuf slot at the end of that cycle.
- Dequeue:
  - `io_deq_valid` = obuf slot0 valid.
  - `io_deq_bits` = slot0 data.
  - deq_fire shifts slot1 into slot0.
- mem_count next = mem_count + enq_fire - rd_fire.
- An entry written in cycle t is counted in mem_count only from t+1, so it is read no earlier than t+1. As a result, the read and write addresses never alias a live entry in the same cycle, and no read-during-write hazard exists.
- Full condition: mem_count==DEPTH deasserts enq_ready. Total capacity is DEPTH+2.
- Simultaneous enq_fire, rd_fire and deq_fire in one cycle are all legal, with counters updated net.
- `io_count` = mem_count + rd_pend + obuf_occ.

## Timing
- Reset values:
  - Pointers, mem_count, rd_pend and obuf valid bits are all 0.
  - `io_enq_ready`=1, `io_deq_valid`=0, `io_sram_weW`=0, `io_count`=0.
  - `io_deq_bits`=0, `io_sram_addrR`=0, `io_sram_addrW`=0.
- Reset asserted mid-operation: all queued and in-flight data is discarded, and a pending SRAM return is ignored. The SRAM contents themselves are not cleared.
- Empty-to-valid latency (bypass off): enq at cycle 0, read at cycle 1, capture at the end of cycle 2, `io_deq_valid` high in cycle 3.
- Steady state: 1 word/cycle in and out with `io_deq_ready` held high.
- `io_deq_bits` is stable while `io_deq_valid` & !`io_deq_ready`.

## Configuration
- Macro: `SRAM_FIFO_CTRL_BYPASS_EN`.
- Defined: when mem_count==0, rd_pend==0, and obuf has a free slot not being refilled, an enq_fire word goes directly into obuf. There is no SRAM write and `io_sram_weW`=0. `io_deq_valid` rises in cycle 1. Ordering is preserved: bypass is never taken while any older word is in SRAM or in flight.
- Undefined: every word passes through the SRAM, with 3-cycle minimum latency.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with random inputs -> `io_enq_ready`=1, `io_deq_valid`=0, `io_sram_weW`=0, `io_count`=0.
- Single word: enq 0xA5 at cycle 0 with deq_ready=1 -> `io_deq_bits`=0xA5, valid in cycle 3 (cycle 1 with bypass), `io_count` returns to 0.
- Fill: DEPTH=64, deq_ready=0, enq 0..69 -> `io_enq_ready` drops after 66 accepted words (`io_count`=66). Then drain -> 0..65 emerge in order.
- Streaming: enq and deq held high for 200 words, incrementing data -> after fill latency, one deq_fire per cycle, no drops or duplicates, and pointers wrap past 63 correctly.
- Backpressure: random deq_ready (50%) with random enq_valid over 5000 cycles, checked against a reference queue model -> order and data match, `io_count` always equals the model occupancy.
- Mid-operation reset: 10 words queued plus a read in flight, pulse `reset_n` low -> queue empty. The next enq 0x3C is the first word dequeued.

Source files
------------

// File: rtl/sram_fifo_ctrl_if.sv
// Bundle of the enqueue stream, dequeue stream and SRAM port signals for sram_fifo_ctrl.
// Valid/ready: a word moves only in a cycle where valid and ready are both high; valid never waits on ready.
interface sram_fifo_ctrl_if #(
  parameter int WIDTH    = 8,
  parameter int LG_DEPTH = 6
);
  logic                io_enq_valid;
  logic                io_enq_ready;
  logic [WIDTH-1:0]    io_enq_bits;
  logic                io_deq_valid;
  logic                io_deq_ready;
  logic [WIDTH-1:0]    io_deq_bits;
  logic [LG_DEPTH+1:0] io_count;
  logic [WIDTH-1:0]    io_sram_dinW;
  logic [LG_DEPTH-1:0] io_sram_addrW;
  logic                io_sram_weW;
  logic [LG_DEPTH-1:0] io_sram_addrR;
  logic [WIDTH-1:0]    io_sram_doutR;

  modport master (
    input  io_enq_valid, io_enq_bits, io_deq_ready, io_sram_doutR,
    output io_enq_ready, io_deq_valid, io_deq_bits, io_count,
           io_sram_dinW, io_sram_addrW, io_sram_weW, io_sram_addrR
  );

  modport slave (
    output io_enq_valid, io_enq_bits, io_deq_ready, io_sram_doutR,
    input  io_enq_ready, io_deq_valid, io_deq_bits, io_count,
           io_sram_dinW, io_sram_addrW, io_sram_weW, io_sram_addrR
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Queue controller driving a 1R/1W SRAM with a 2-entry output buffer hiding read latency.
// Optional macro SRAM_FIFO_CTRL_BYPASS_EN lets words skip the SRAM when the queue is drained.
module sram_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int LG_DEPTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sram_fifo_ctrl_if.master      bus
);
  localparam logic [LG_DEPTH:0] L_FULL = (LG_DEPTH+1)'(DEPTH);

  logic [LG_DEPTH-1:0] r_wr_ptr;
  logic [LG_DEPTH-1:0] r_rd_ptr;
  logic [LG_DEPTH:0]   r_mem_count;
  logic                r_rd_pend;
  logic [1:0]          r_ob_vld;
  logic [WIDTH-1:0]    r_ob_data [2];

  logic                w_enq_ready;
  logic                w_enq_fire;
  logic                w_deq_fire;
  logic                w_rd_fire;
  logic                w_bypass;
  logic                w_mem_wr;
  logic                w_ins;
  logic [WIDTH-1:0]    w_ins_data;
  logic [1:0]          w_occ;
  logic [2:0]          w_rd_slots;
  logic [1:0]          w_nx_vld;
  logic [WIDTH-1:0]    w_nx_data [2];

  assign w_enq_ready = (r_mem_count < L_FULL);
  assign w_enq_fire  = bus.io_enq_valid & w_enq_ready;
  assign w_deq_fire  = r_ob_vld[0] & bus.io_deq_ready;
  assign w_occ       = {1'b0, r_ob_vld[0]} + {1'b0, r_ob_vld[1]};

  // Slots still claimed after this cycle's dequeue; a new read needs one spare.
  assign w_rd_slots  = {1'b0, w_occ} + {2'b0, r_rd_pend} - {2'b0, w_deq_fire};
  assign w_rd_fire   = (r_mem_count != '0) && (w_rd_slots < 3'd2);

`ifdef SRAM_FIFO_CTRL_BYPASS_EN
  // Nothing older sits in SRAM or in flight, so the word may go straight to the buffer.
  assign w_bypass = w_enq_fire && (r_mem_count == '0) && !r_rd_pend &&
                    (({1'b0, w_occ} - {2'b0, w_deq_fire}) < 3'd2);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_mem_wr   = w_enq_fire & ~w_bypass;
  assign w_ins      = r_rd_pend | w_bypass;
  assign w_ins_data = r_rd_pend ? bus.io_sram_doutR : bus.io_enq_bits;

  always_comb begin
    w_nx_vld     = r_ob_vld;
    w_nx_data[0] = r_ob_data[0];
    w_nx_data[1] = r_ob_data[1];
    if (w_deq_fire) begin
      w_nx_vld     = {1'b0, r_ob_vld[1]};
      w_nx_data[0] = r_ob_data[1];
    end
    if (w_ins) begin
      if (!w_nx_vld[0]) begin
        w_nx_vld[0]  = 1'b1;
        w_nx_data[0] = w_ins_data;
      end else begin
        w_nx_vld[1]  = 1'b1;
        w_nx_data[1] = w_ins_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mem_count  <= '0;
      r_rd_pend    <= 1'b0;
      r_ob_vld     <= 2'b00;
      r_ob_data[0] <= '0;
      r_ob_data[1] <= '0;
    end else begin
      if (w_mem_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_mem_count  <= r_mem_count + (LG_DEPTH+1)'(w_mem_wr) - (LG_DEPTH+1)'(w_rd_fire);
      r_rd_pend    <= w_rd_fire;
      r_ob_vld     <= w_nx_vld;
      r_ob_data[0] <= w_nx_data[0];
      r_ob_data[1] <= w_nx_data[1];
    end
  end

  assign bus.io_enq_ready  = w_enq_ready;
  assign bus.io_deq_valid  = r_ob_vld[0];
  assign bus.io_deq_bits   = r_ob_data[0];
  assign bus.io_count      = (LG_DEPTH+2)'(r_mem_count) + (LG_DEPTH+2)'(r_rd_pend) +
                             (LG_DEPTH+2)'(w_occ);
  assign bus.io_sram_dinW  = bus.io_enq_bits;
  assign bus.io_sram_addrW = r_wr_ptr;
  assign bus.io_sram_weW   = w_mem_wr;
  assign bus.io_sram_addrR = r_rd_ptr;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed and randomized bench for sram_fifo_ctrl with an SRAM model and a reference queue.
module tb_sram_fifo_ctrl;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 64;
  localparam int LG_DEPTH = 6;
`ifdef SRAM_FIFO_CTRL_BYPASS_EN
  localparam int LAT = 1;
  localparam logic EXP_WE = 1'b0;
`else
  localparam int LAT = 3;
  localparam logic EXP_WE = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sram_fifo_ctrl_if #(.WIDTH(WIDTH), .LG_DEPTH(LG_DEPTH)) bus ();

  sram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LG_DEPTH(LG_DEPTH)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [WIDTH-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.io_sram_weW) sram_mem[bus.io_sram_addrW] <= bus.io_sram_dinW;
    bus.io_sram_doutR <= sram_mem[bus.io_sram_addrR];
  end

  logic [WIDTH-1:0] exp_q [$];
  int n_cmp = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_deq = 0;
  int cyc = 0;
  int last_deq_cyc = 0;
  logic stall_prev = 1'b0;
  logic [WIDTH-1:0] stall_bits = '0;
  logic chk_count = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, account handshakes against the model, advance to the next negedge.
  task automatic cycle(input logic ev, input logic [WIDTH-1:0] eb, input logic dr, input logic rn);
    bus.io_enq_valid = ev;
    bus.io_enq_bits  = eb;
    bus.io_deq_ready = dr;
    reset_n          = rn;
    #1;
    if (rn) begin
      if (stall_prev) check("deq_bits_stable", 32'(bus.io_deq_bits), 32'(stall_bits));
      if (bus.io_deq_valid && dr) begin
        check("deq_model_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("deq_data", 32'(bus.io_deq_bits), 32'(exp_q.pop_front()));
        n_deq++;
        last_deq_cyc = cyc;
      end
      if (ev && bus.io_enq_ready) begin
        exp_q.push_back(eb);
        n_acc++;
      end
      stall_prev = bus.io_deq_valid && !dr;
      stall_bits = bus.io_deq_bits;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rn) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end
    if (chk_count) check("count", 32'(bus.io_count), 32'(exp_q.size()));
  endtask

  initial begin
    int c0, a0, d0, nxt;
    bus.io_enq_valid = 1'b0;
    bus.io_enq_bits  = '0;
    bus.io_deq_ready = 1'b0;
    reset_n          = 1'b0;
    @(negedge clk);

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      cycle(1'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    bus.io_enq_valid = 1'b0;
    #1;
    check("rst_enq_ready", 32'(bus.io_enq_ready), 32'd1);
    check("rst_deq_valid", 32'(bus.io_deq_valid), 32'd0);
    check("rst_weW", 32'(bus.io_sram_weW), 32'd0);
    check("rst_count", 32'(bus.io_count), 32'd0);
    check("rst_deq_bits", 32'(bus.io_deq_bits), 32'd0);
    check("rst_addrR", 32'(bus.io_sram_addrR), 32'd0);
    check("rst_addrW", 32'(bus.io_sram_addrW), 32'd0);
    chk_count = 1'b1;

    // Single word latency
    bus.io_enq_valid = 1'b1;
    bus.io_enq_bits  = 8'hA5;
    reset_n          = 1'b1;
    #1;
    check("single_weW", 32'(bus.io_sram_weW), 32'(EXP_WE));
    c0 = cyc;
    d0 = n_deq;
    cycle(1'b1, 8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 10 && n_deq == d0; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    check("single_deq_seen", 32'(n_deq - d0), 32'd1);
    check("single_latency", 32'(last_deq_cyc - c0), 32'(LAT));
    cycle(1'b0, '0, 1'b1, 1'b1);

    // Fill with no dequeue
    a0 = n_acc;
    nxt = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(1'b1, WIDTH'(nxt), 1'b0, 1'b1);
      nxt = n_acc - a0;
    end
    check("fill_accepted", 32'(n_acc - a0), 32'd66);
    check("fill_count", 32'(bus.io_count), 32'd66);
    check("fill_enq_ready", 32'(bus.io_enq_ready), 32'd0);
    d0 = n_deq;
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    check("fill_drained", 32'(n_deq - d0), 32'd66);

    // Streaming: one word per cycle in and out, pointers wrap
    c0 = cyc;
    a0 = n_acc;
    d0 = n_deq;
    for (int i = 0; i < 200; i++) cycle(1'b1, WIDTH'(i + 7), 1'b1, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    check("stream_accepted", 32'(n_acc - a0), 32'd200);
    check("stream_dequeued", 32'(n_deq - d0), 32'd200);
    check("stream_last_cycle", 32'(last_deq_cyc - c0), 32'(199 + LAT));

    // Random backpressure
    for (int i = 0; i < 5000; i++)
      cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Reset with words queued and a read in flight
    for (int i = 0; i < 10; i++) cycle(1'b1, WIDTH'(8'h50 + i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("midrst_deq_valid", 32'(bus.io_deq_valid), 32'd0);
    d0 = n_deq;
    cycle(1'b1, 8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 10 && n_deq == d0; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    check("midrst_first_deq", 32'(n_deq - d0), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
